// File: rtl/cfg_pkt_writer.sv
// Parses SpaceWire config-write packets (addr bytes, data bytes, EOP) from the rx FIFO into one register write each; optional CFG_WR_ACK_EN holds cfg_wr_o until cfg_wr_ack_i.
// Latency: EOP read to cfg_wr_o is 2 cycles; FIFO reads follow occupancy and stall while a write is in flight.
module cfg_pkt_writer #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [8:0]    fifo_data_i,
  input  logic          fifo_empty_i,
  output logic          fifo_rd_o,
  output logic          cfg_wr_o,
  output logic [AW-1:0] cfg_wr_addr_o,
  output logic [DW-1:0] cfg_wr_data_o,
  input  logic          cfg_wr_ack_i,
  output logic          cfg_wrbusy_o,
  output logic          cfg_int_o,
  output logic [AW-1:0] cfg_int_addr,
  output logic          cfg_err_o
);
  localparam int AB = AW / 8;
  localparam int DB = DW / 8;
  localparam int CW = 8;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, TAIL, WRITE, DISCARD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] int_addr_q, int_addr_d;
  logic          err_q, err_d;
  logic          rd_vld_q;
  logic          rd_en;
  logic          wr_done;
  logic          is_data, is_eop, is_eep;

  // Any control char other than EOP terminates the packet as an error end.
  assign is_data = rd_vld_q && !fifo_data_i[8];
  assign is_eop  = rd_vld_q && fifo_data_i[8] && (fifo_data_i[7:0] == 8'h00);
  assign is_eep  = rd_vld_q && fifo_data_i[8] && (fifo_data_i[7:0] != 8'h00);

`ifdef CFG_WR_ACK_EN
  assign wr_done = cfg_wr_ack_i;
`else
  logic unused_ack;
  assign unused_ack = cfg_wr_ack_i;
  assign wr_done    = 1'b1;
`endif

  always_comb begin
    rd_en = 1'b0;
    case (state_q)
      IDLE, ADDR, DATA, DISCARD: rd_en = 1'b1;
      TAIL:                      rd_en = !rd_vld_q;
      default:                   rd_en = 1'b0;
    endcase
  end

  assign fifo_rd_o = rd_en && !fifo_empty_i && !reset;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    int_addr_d = int_addr_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_data) begin
          addr_d = AW'(fifo_data_i[7:0]);
          if (AB == 1) begin
            cnt_d   = '0;
            state_d = DATA;
          end else begin
            cnt_d   = CW'(1);
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (is_data) begin
          addr_d = (addr_q << 8) | AW'(fifo_data_i[7:0]);
          if (cnt_q == CW'(AB - 1)) begin
            cnt_d   = '0;
            state_d = DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (is_eop || is_eep) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DATA: begin
        if (is_data) begin
          data_d = (data_q << 8) | DW'(fifo_data_i[7:0]);
          if (cnt_q == CW'(DB - 1)) begin
            cnt_d   = '0;
            state_d = TAIL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (is_eop || is_eep) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      TAIL: begin
        if (is_eop) begin
          state_d = WRITE;
        end else if (is_eep) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (is_data) begin
          state_d = DISCARD;
        end
      end
      WRITE: begin
        if (wr_done) begin
          int_addr_d = addr_q;
          state_d    = IDLE;
        end
      end
      DISCARD: begin
        if (is_eop || is_eep) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      int_addr_q <= '0;
      err_q      <= 1'b0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      int_addr_q <= int_addr_d;
      err_q      <= err_d;
      rd_vld_q   <= fifo_rd_o;
    end
  end

  assign cfg_wr_o      = (state_q == WRITE);
  assign cfg_wr_addr_o = addr_q;
  assign cfg_wr_data_o = data_q;
  assign cfg_int_o     = cfg_wr_o && wr_done;
  // The completing write's address is visible in its own interrupt cycle.
  assign cfg_int_addr  = cfg_int_o ? addr_q : int_addr_q;
  assign cfg_wrbusy_o  = (state_q != IDLE);
  assign cfg_err_o     = err_q;

endmodule

// File: tb/tb_cfg_pkt_writer.sv
// Randomized bench for cfg_pkt_writer: FIFO model feeds chars, a packet-level model predicts writes and errors.
`timescale 1ns/1ps
module tb_cfg_pkt_writer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int AB = AW / 8;
  localparam int DB = DW / 8;
`ifdef CFG_WR_ACK_EN
  localparam bit ACK_EN  = 1'b1;
  localparam int ACK_DLY = 5;
`else
  localparam bit ACK_EN  = 1'b0;
  localparam int ACK_DLY = 0;
`endif
  localparam logic [8:0] EOP   = 9'h100;
  localparam logic [8:0] EEP   = 9'h101;
  localparam logic [1:0] K_WR  = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  typedef struct packed {
    logic [1:0]    kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          int_ok;
    logic [AW-1:0] int_addr;
    logic          busy;
    logic [7:0]    len;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [8:0]    fifo_data_i;
  logic          fifo_empty_i;
  logic          fifo_rd_o;
  logic          cfg_wr_o;
  logic [AW-1:0] cfg_wr_addr_o;
  logic [DW-1:0] cfg_wr_data_o;
  logic          cfg_wr_ack_i;
  logic          cfg_wrbusy_o;
  logic          cfg_int_o;
  logic [AW-1:0] cfg_int_addr;
  logic          cfg_err_o;

  cfg_pkt_writer #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i), .fifo_rd_o(fifo_rd_o),
    .cfg_wr_o(cfg_wr_o), .cfg_wr_addr_o(cfg_wr_addr_o), .cfg_wr_data_o(cfg_wr_data_o),
    .cfg_wr_ack_i(cfg_wr_ack_i), .cfg_wrbusy_o(cfg_wrbusy_o), .cfg_int_o(cfg_int_o),
    .cfg_int_addr(cfg_int_addr), .cfg_err_o(cfg_err_o)
  );

  always #5 clk = ~clk;

  logic [8:0]  fifo_q[$];
  ev_t         exp_q[$];
  ev_t         obs_q[$];
  logic [7:0]  cur_pkt[$];
  logic [AW-1:0] last_wr_addr = '0;
  int vectors = 0;
  int miscompares = 0;
  int rd_empty_cnt = 0;
  int rd_in_wr_cnt = 0;
  int int_no_wr_cnt = 0;
  int gate_mode = 0;
  bit rd_seen = 1'b0;

  // Monitor: sample outputs mid-cycle and log write/error events.
  initial begin
    int wr_run;
    bit ack_eff;
    wr_run = 0;
    forever begin
      @(negedge clk);
      rd_seen = fifo_rd_o;
      if (!reset) begin
        ack_eff = ACK_EN ? cfg_wr_ack_i : 1'b1;
        if (fifo_rd_o && fifo_empty_i) rd_empty_cnt++;
        if (fifo_rd_o && cfg_wr_o) rd_in_wr_cnt++;
        if (cfg_int_o && !(cfg_wr_o && ack_eff)) int_no_wr_cnt++;
        wr_run = cfg_wr_o ? wr_run + 1 : 0;
        if (cfg_wr_o && ack_eff)
          obs_q.push_back('{kind: K_WR, addr: cfg_wr_addr_o, data: cfg_wr_data_o, int_ok: cfg_int_o,
                            int_addr: cfg_int_addr, busy: cfg_wrbusy_o, len: 8'(wr_run)});
        if (cfg_err_o)
          obs_q.push_back('{kind: K_ERR, default: '0});
      end
    end
  end

  // FIFO and ack environment: pops on a seen read, presents data one cycle later.
  initial begin
    bit tgl, stall;
    int ack_cnt;
    tgl = 1'b0; ack_cnt = 0;
    fifo_data_i = '0; fifo_empty_i = 1'b1; cfg_wr_ack_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_seen && fifo_q.size() > 0) fifo_data_i = fifo_q.pop_front();
      tgl = ~tgl;
      case (gate_mode)
        1:       stall = tgl;
        2:       stall = ($urandom_range(0, 2) == 0);
        default: stall = 1'b0;
      endcase
      fifo_empty_i = (fifo_q.size() == 0) || stall;
      if (ACK_EN) begin
        if (cfg_wr_o) begin
          ack_cnt++;
          cfg_wr_ack_i = (ack_cnt > ACK_DLY);
        end else begin
          ack_cnt = 0;
          cfg_wr_ack_i = 1'b0;
        end
      end else begin
        cfg_wr_ack_i = 1'($urandom_range(0, 1));
      end
    end
  end

  // Reference model: a packet is written only if it holds exactly AB+DB bytes and ends in EOP.
  task automatic push_char(input logic [8:0] c);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    fifo_q.push_back(c);
    if (!c[8]) begin
      cur_pkt.push_back(c[7:0]);
    end else if (cur_pkt.size() != 0) begin
      if (c == EOP && cur_pkt.size() == AB + DB) begin
        a = '0; d = '0;
        for (int i = 0; i < AB; i++) a = a * 256 + AW'(cur_pkt[i]);
        for (int i = 0; i < DB; i++) d = d * 256 + DW'(cur_pkt[AB + i]);
        exp_q.push_back('{kind: K_WR, addr: a, data: d, int_ok: 1'b1, int_addr: a,
                          busy: 1'b1, len: 8'(ACK_DLY + 1)});
        last_wr_addr = a;
      end else begin
        exp_q.push_back('{kind: K_ERR, default: '0});
      end
      cur_pkt.delete();
    end
  endtask

  task automatic push_pkt(input int n, input logic [8:0] term);
    for (int i = 0; i < n; i++) push_char({1'b0, 8'($urandom_range(0, 255))});
    push_char(term);
  endtask

  task automatic run(input int ob, input int eb, input bit need_idle, output bit to);
    int idle;
    idle = 0;
    for (int n = 0; n < 5000 && idle < 4; n++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && !fifo_rd_o &&
          (!need_idle || (!cfg_wrbusy_o && (obs_q.size() - ob) >= (exp_q.size() - eb))))
        idle++;
      else
        idle = 0;
    end
    to = (idle < 4);
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++;
    if ({fifo_rd_o, cfg_wr_o, cfg_wrbusy_o, cfg_int_o, cfg_err_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got rd/wr/busy/int/err=%b want 00000",
               {fifo_rd_o, cfg_wr_o, cfg_wrbusy_o, cfg_int_o, cfg_err_o});
    end
    vectors++;
    if ({cfg_wr_addr_o, cfg_wr_data_o, cfg_int_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_bus got addr=%h data=%h int_addr=%h want 0", cfg_wr_addr_o, cfg_wr_data_o, cfg_int_addr);
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cfg_wrbusy_o, cfg_err_o, cfg_wr_o} !== 3'b0) begin
      miscompares++;
      $display("FAIL reset_idle got busy/err/wr=%b want 000", {cfg_wrbusy_o, cfg_err_o, cfg_wr_o});
    end
  endtask

  task automatic test_basic;
    logic [8:0] ch[9] = '{9'h012, 9'h034, 9'h056, 9'h078, 9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD, 9'h100};
    int ob, eb; bit to; ev_t got;
    ob = obs_q.size(); eb = exp_q.size(); gate_mode = 0;
    foreach (ch[i]) push_char(ch[i]);
    run(ob, eb, 1'b1, to);
    got = (obs_q.size() > ob) ? obs_q[ob] : '0;
    vectors++;
    if (to || obs_q.size() - ob !== 1) begin
      miscompares++;
      $display("FAIL basic_count got timeout=%0b events=%0d want 0/1", to, obs_q.size() - ob);
    end
    vectors++;
    if (got.kind !== K_WR || got.addr !== 32'h12345678 || got.data !== 32'hAABBCCDD) begin
      miscompares++;
      $display("FAIL basic_write got kind=%0d addr=%h data=%h want 1/12345678/aabbccdd", got.kind, got.addr, got.data);
    end
    vectors++;
    if (got !== exp_q[eb]) begin
      miscompares++;
      $display("FAIL basic_event got %h want %h", got, exp_q[eb]);
    end
    vectors++;
    if (cfg_int_addr !== 32'h12345678) begin
      miscompares++;
      $display("FAIL basic_int_hold got %h want 12345678", cfg_int_addr);
    end
  endtask

  task automatic test_empty_pkts;
    int ob, eb; bit to; ev_t got;
    ob = obs_q.size(); eb = exp_q.size(); gate_mode = 0;
    push_char(EOP); push_char(EOP); push_pkt(AB + DB, EOP);
    run(ob, eb, 1'b1, to);
    vectors++;
    if (to || obs_q.size() - ob !== 1) begin
      miscompares++;
      $display("FAIL empty_count got timeout=%0b events=%0d want 0/1", to, obs_q.size() - ob);
    end
    got = (obs_q.size() > ob) ? obs_q[ob] : '0;
    vectors++;
    if (got !== exp_q[eb]) begin
      miscompares++;
      $display("FAIL empty_event got %h want %h", got, exp_q[eb]);
    end
  endtask

  task automatic test_eep_trunc;
    int ob, eb; bit to; ev_t got;
    ob = obs_q.size(); eb = exp_q.size(); gate_mode = 0;
    push_char(9'h012); push_char(9'h034); push_char(9'h056); push_char(EEP);
    push_pkt(AB + DB, EOP);
    run(ob, eb, 1'b1, to);
    vectors++;
    if (to || obs_q.size() - ob !== 2) begin
      miscompares++;
      $display("FAIL eep_count got timeout=%0b events=%0d want 0/2", to, obs_q.size() - ob);
    end
    for (int i = 0; i < 2; i++) begin
      got = (ob + i < obs_q.size()) ? obs_q[ob + i] : '0;
      vectors++;
      if (got !== exp_q[eb + i]) begin
        miscompares++;
        $display("FAIL eep_ev%0d got %h want %h", i, got, exp_q[eb + i]);
      end
    end
    vectors++;
    if (cfg_wrbusy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL eep_busy got %b want 0", cfg_wrbusy_o);
    end
  endtask

  task automatic test_too_long;
    int ob, eb; bit to; ev_t got;
    ob = obs_q.size(); eb = exp_q.size(); gate_mode = 0;
    push_pkt(AB + DB + 1, EOP);
    run(ob, eb, 1'b1, to);
    got = (obs_q.size() > ob) ? obs_q[ob] : '0;
    vectors++;
    if (to || obs_q.size() - ob !== 1 || got.kind !== K_ERR) begin
      miscompares++;
      $display("FAIL long_discard got timeout=%0b events=%0d kind=%0d want 0/1/2", to, obs_q.size() - ob, got.kind);
    end
  endtask

  task automatic test_fifo_toggle;
    int ob, eb, re; bit to; ev_t got;
    ob = obs_q.size(); eb = exp_q.size(); re = rd_empty_cnt; gate_mode = 1;
    push_pkt(AB + DB, EOP);
    run(ob, eb, 1'b1, to);
    got = (obs_q.size() > ob) ? obs_q[ob] : '0;
    vectors++;
    if (to || obs_q.size() - ob !== 1 || got !== exp_q[eb]) begin
      miscompares++;
      $display("FAIL toggle_write got timeout=%0b events=%0d ev=%h want %h", to, obs_q.size() - ob, got, exp_q[eb]);
    end
    vectors++;
    if (rd_empty_cnt - re !== 0) begin
      miscompares++;
      $display("FAIL toggle_rd_empty got %0d reads while empty want 0", rd_empty_cnt - re);
    end
  endtask

  task automatic test_back_to_back;
    int ob, eb, rw, iw; bit to; ev_t got;
    ob = obs_q.size(); eb = exp_q.size(); rw = rd_in_wr_cnt; iw = int_no_wr_cnt; gate_mode = 0;
    for (int p = 0; p < 4; p++) push_pkt(AB + DB, EOP);
    run(ob, eb, 1'b1, to);
    vectors++;
    if (to || obs_q.size() - ob !== 4) begin
      miscompares++;
      $display("FAIL b2b_count got timeout=%0b events=%0d want 0/4", to, obs_q.size() - ob);
    end
    for (int i = 0; i < 4; i++) begin
      got = (ob + i < obs_q.size()) ? obs_q[ob + i] : '0;
      vectors++;
      if (got !== exp_q[eb + i]) begin
        miscompares++;
        $display("FAIL b2b_ev%0d got %h want %h", i, got, exp_q[eb + i]);
      end
    end
    vectors++;
    if (rd_in_wr_cnt - rw !== 0 || int_no_wr_cnt - iw !== 0) begin
      miscompares++;
      $display("FAIL b2b_stall got rd_in_write=%0d stray_int=%0d want 0/0", rd_in_wr_cnt - rw, int_no_wr_cnt - iw);
    end
  endtask

  task automatic test_reset_mid;
    int ob, eb; bit to; ev_t got;
    ob = obs_q.size(); eb = exp_q.size(); gate_mode = 0;
    push_char(9'h012); push_char(9'h034);
    run(ob, eb, 1'b0, to);
    @(posedge clk); #1 reset = 1'b1;
    cur_pkt.delete();
    @(posedge clk); #1 reset = 1'b0;
    push_pkt(AB + DB - 1, EOP);
    push_pkt(AB + DB, EOP);
    run(ob, eb, 1'b1, to);
    vectors++;
    if (to || obs_q.size() - ob !== 2) begin
      miscompares++;
      $display("FAIL rstmid_count got timeout=%0b events=%0d want 0/2", to, obs_q.size() - ob);
    end
    for (int i = 0; i < 2; i++) begin
      got = (ob + i < obs_q.size()) ? obs_q[ob + i] : '0;
      vectors++;
      if (got !== exp_q[eb + i]) begin
        miscompares++;
        $display("FAIL rstmid_ev%0d got %h want %h", i, got, exp_q[eb + i]);
      end
    end
  endtask

  task automatic test_random;
    int ob, eb, re, k; bit to; ev_t got;
    ob = obs_q.size(); eb = exp_q.size(); re = rd_empty_cnt; gate_mode = 2;
    for (int p = 0; p < 40; p++) begin
      k = $urandom_range(0, 5);
      case (k)
        0:       push_pkt(0, ($urandom_range(0, 1) != 0) ? EOP : EEP);
        2:       push_pkt(AB + DB, EEP);
        3:       push_pkt($urandom_range(1, AB + DB - 1), ($urandom_range(0, 1) != 0) ? EOP : EEP);
        4:       push_pkt($urandom_range(AB + DB + 1, AB + DB + 4), EOP);
        default: push_pkt(AB + DB, EOP);
      endcase
    end
    run(ob, eb, 1'b1, to);
    vectors++;
    if (to || obs_q.size() - ob !== exp_q.size() - eb) begin
      miscompares++;
      $display("FAIL rand_count got timeout=%0b events=%0d want 0/%0d", to, obs_q.size() - ob, exp_q.size() - eb);
    end
    for (int i = 0; i < exp_q.size() - eb; i++) begin
      got = (ob + i < obs_q.size()) ? obs_q[ob + i] : '0;
      vectors++;
      if (got !== exp_q[eb + i]) begin
        miscompares++;
        $display("FAIL rand_ev%0d got %h want %h", i, got, exp_q[eb + i]);
      end
    end
    vectors++;
    if (rd_empty_cnt - re !== 0 || cfg_int_addr !== last_wr_addr) begin
      miscompares++;
      $display("FAIL rand_tail got rd_empty=%0d int_addr=%h want 0/%h", rd_empty_cnt - re, cfg_int_addr, last_wr_addr);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_empty_pkts;
    test_eep_trunc;
    test_too_long;
    test_fifo_toggle;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
